// File: rtl/program_counter_unit_pkg.sv
// ---------------------------------------------------------------------------
// programCounterGroup
//   Shared definitions for the cpu32e2 program counter.
//   - controlBus   : registered control code issued by the controller.
//   - ALIGN_MASK   : low address bits that must be zero for a legal target.
//   - vectorAddress: ISR entry address, word-aligned base plus index * 4.
// ---------------------------------------------------------------------------
package programCounterGroup;

  typedef enum logic [2:0] {
    NO_OP      = 3'd0,
    LOAD_PLUS4 = 3'd1,
    LOAD_RFA   = 3'd2,
    LOAD_CALC  = 3'd3,
    LOAD_ISR   = 3'd4
  } controlBus;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // The low two bits of the base are dropped.
  // The sum wraps modulo 2^32.
  function automatic logic [31:0] vectorAddress(input logic [31:0] base,
                                                input logic [4:0]  index);
    logic [31:0] aligned_base;
    logic [31:0] offset;
    aligned_base = {base[31:2], 2'b00};
    offset       = {25'd0, index, 2'b00};
    return aligned_base + offset;
  endfunction

endpackage

// File: rtl/program_counter_unit_pc_target_select.sv
// ---------------------------------------------------------------------------
// pc_target_select
//   Combinational next-PC mux with branch-target alignment check.
//   Inputs : pcControl, pc, rfaData, calcData, vectorBase, vectorIndex
//   Outputs: nextPc      - candidate next PC value
//            loadPc      - nextPc should be written into pc
//            faultDetect - register/calculated target is misaligned
//            faultTarget - the misaligned target address
// ---------------------------------------------------------------------------
module pc_target_select
  import programCounterGroup::*;
(
  input  controlBus   pcControl,
  input  logic [31:0] pc,
  input  logic [31:0] rfaData,
  input  logic [31:0] calcData,
  input  logic [31:0] vectorBase,
  input  logic [4:0]  vectorIndex,
  output logic [31:0] nextPc,
  output logic        loadPc,
  output logic        faultDetect,
  output logic [31:0] faultTarget
);

  logic [31:0] branch_target;
  logic        is_branch;

  always_comb begin
    branch_target = rfaData;
    is_branch     = 1'b0;
    case (pcControl)
      LOAD_RFA:  begin branch_target = rfaData;  is_branch = 1'b1; end
      LOAD_CALC: begin branch_target = calcData; is_branch = 1'b1; end
      default:   ;
    endcase
  end

  always_comb begin
    nextPc      = pc;
    loadPc      = 1'b0;
    faultDetect = 1'b0;
    faultTarget = branch_target;
    case (pcControl)
      LOAD_PLUS4: begin
        nextPc = pc + 32'd4;
        loadPc = 1'b1;
      end
      LOAD_RFA, LOAD_CALC: begin
        // A misaligned target never reaches pc.
        // It is only reported as a fault.
        if ((branch_target[1:0] & ALIGN_MASK) == 2'b00) begin
          nextPc = branch_target;
          loadPc = 1'b1;
        end else begin
          faultDetect = is_branch;
        end
      end
      LOAD_ISR: begin
        nextPc = vectorAddress(vectorBase, vectorIndex);
        loadPc = 1'b1;
      end
      default: ;  // NO_OP and undefined codes hold.
    endcase
  end

endmodule

// File: rtl/program_counter_unit.sv
// ---------------------------------------------------------------------------
// program_counter_unit
//   Architectural PC for the cpu32e2 core.
//   It holds pc, the interrupted PC (savedPc) and a sticky alignment-fault
//   record.
//   Parameter: RESET_VECTOR - pc value after reset (bits [1:0] must be 0)
//   Inputs : clk, reset (async, active-high), enable, pcControl, rfaData,
//            calcData, vectorBase, vectorIndex, faultAck
//   Outputs: pc, pcPlus4 (combinational), savedPc, alignFault, faultAddr
// ---------------------------------------------------------------------------
module program_counter_unit
  import programCounterGroup::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  controlBus   pcControl,
  input  logic [31:0] rfaData,
  input  logic [31:0] calcData,
  input  logic [31:0] vectorBase,
  input  logic [4:0]  vectorIndex,
  input  logic        faultAck,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] savedPc,
  output logic        alignFault,
  output logic [31:0] faultAddr
);

  logic [31:0] next_pc;
  logic        load_pc;
  logic        fault_detect;
  logic [31:0] fault_target;
  logic        capture_fault;

  pc_target_select u_target_select (
    .pcControl   (pcControl),
    .pc          (pc),
    .rfaData     (rfaData),
    .calcData    (calcData),
    .vectorBase  (vectorBase),
    .vectorIndex (vectorIndex),
    .nextPc      (next_pc),
    .loadPc      (load_pc),
    .faultDetect (fault_detect),
    .faultTarget (fault_target)
  );

  assign pcPlus4 = pc + 32'd4;

  // The first fault owns faultAddr until it is acknowledged.
  // A fault arriving in the same cycle as the acknowledge replaces the
  // record instead of being lost.
  assign capture_fault = enable && fault_detect && (!alignFault || faultAck);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      savedPc <= 32'd0;
    end else if (enable) begin
      if (load_pc) pc <= next_pc;
      if (pcControl == LOAD_ISR) savedPc <= pc;
    end
  end

  // The acknowledge is honoured even while the core is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alignFault <= 1'b0;
      faultAddr  <= 32'd0;
    end else if (capture_fault) begin
      alignFault <= 1'b1;
      faultAddr  <= fault_target;
    end else if (faultAck) begin
      alignFault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit. Inputs change 1 ns after each
// rising edge; outputs are checked at that same point.
module tb_program_counter_unit;
  import programCounterGroup::*;

  logic        clk;
  logic        reset;
  logic        enable;
  controlBus   pcControl;
  logic [31:0] rfaData;
  logic [31:0] calcData;
  logic [31:0] vectorBase;
  logic [4:0]  vectorIndex;
  logic        faultAck;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] savedPc;
  logic        alignFault;
  logic [31:0] faultAddr;

  int total_checks;
  int passed_checks;

  program_counter_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pcControl   (pcControl),
    .rfaData     (rfaData),
    .calcData    (calcData),
    .vectorBase  (vectorBase),
    .vectorIndex (vectorIndex),
    .faultAck    (faultAck),
    .pc          (pc),
    .pcPlus4     (pcPlus4),
    .savedPc     (savedPc),
    .alignFault  (alignFault),
    .faultAddr   (faultAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input controlBus code, input logic en, input logic ack);
    pcControl = code;
    enable    = en;
    faultAck  = ack;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    reset = 1'b1; enable = 1'b0; pcControl = NO_OP; rfaData = '0; calcData = '0;
    vectorBase = '0; vectorIndex = '0; faultAck = 1'b0;

    step();
    check32("reset_pc", pc, 32'h0);
    check32("reset_pcplus4", pcPlus4, 32'h4);
    check32("reset_savedpc", savedPc, 32'h0);
    check32("reset_alignfault", {31'd0, alignFault}, 32'h0);
    check32("reset_faultaddr", faultAddr, 32'h0);
    reset = 1'b0;

    drive(LOAD_PLUS4, 1'b1, 1'b0);
    step(); check32("plus4_1", pc, 32'h4);
    step(); check32("plus4_2", pc, 32'h8);
    step(); check32("plus4_3", pc, 32'hC);
    check32("pcplus4_at_c", pcPlus4, 32'h10);

    drive(LOAD_CALC, 1'b1, 1'b0); calcData = 32'hFFFF_FFFC;
    step(); check32("calc_top", pc, 32'hFFFF_FFFC);
    drive(LOAD_PLUS4, 1'b1, 1'b0);
    step(); check32("plus4_wrap", pc, 32'h0);

    drive(LOAD_CALC, 1'b1, 1'b0); calcData = 32'h0000_1000;
    step(); check32("calc_1000", pc, 32'h1000);
    drive(LOAD_PLUS4, 1'b0, 1'b0);
    step(); check32("stall_1", pc, 32'h1000);
    step(); check32("stall_2", pc, 32'h1000);
    drive(controlBus'(3'd7), 1'b1, 1'b0);
    step(); check32("undef_code", pc, 32'h1000);

    drive(LOAD_RFA, 1'b1, 1'b0); rfaData = 32'h0000_2002;
    step();
    check32("misalign_pc", pc, 32'h1000);
    check32("misalign_flag", {31'd0, alignFault}, 32'h1);
    check32("misalign_addr", faultAddr, 32'h2002);
    drive(LOAD_CALC, 1'b1, 1'b0); calcData = 32'h0000_3001;
    step(); check32("first_fault_wins", faultAddr, 32'h2002);
    calcData = 32'h0000_0500;
    step();
    check32("legal_while_faulted_pc", pc, 32'h500);
    check32("legal_while_faulted_flag", {31'd0, alignFault}, 32'h1);
    drive(NO_OP, 1'b1, 1'b1);
    step(); check32("ack_clears", {31'd0, alignFault}, 32'h0);

    drive(LOAD_CALC, 1'b1, 1'b1); calcData = 32'h0000_4003;
    step();
    check32("ack_vs_fault_flag", {31'd0, alignFault}, 32'h1);
    check32("ack_vs_fault_addr", faultAddr, 32'h4003);
    check32("ack_vs_fault_pc", pc, 32'h500);

    drive(NO_OP, 1'b0, 1'b1);
    step(); check32("ack_while_stalled", {31'd0, alignFault}, 32'h0);
    drive(LOAD_RFA, 1'b0, 1'b0); rfaData = 32'h0000_7001;
    step();
    check32("stalled_fault_flag", {31'd0, alignFault}, 32'h0);
    check32("stalled_fault_addr", faultAddr, 32'h4003);

    drive(LOAD_ISR, 1'b1, 1'b0); vectorBase = 32'h0000_8003; vectorIndex = 5'd5;
    step();
    check32("isr_savedpc", savedPc, 32'h500);
    check32("isr_pc", pc, 32'h8014);

    drive(LOAD_RFA, 1'b1, 1'b0); rfaData = 32'h0000_0002;
    step();
    check32("prereset_flag", {31'd0, alignFault}, 32'h1);
    check32("prereset_pc", pc, 32'h8014);
    drive(LOAD_PLUS4, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check32("async_reset_pc", pc, 32'h0);
    check32("async_reset_flag", {31'd0, alignFault}, 32'h0);
    check32("async_reset_savedpc", savedPc, 32'h0);
    check32("async_reset_faultaddr", faultAddr, 32'h0);
    step();
    check32("reset_held_pc", pc, 32'h0);
    reset = 1'b0;

    drive(LOAD_ISR, 1'b1, 1'b0); vectorBase = 32'hFFFF_FFF0; vectorIndex = 5'd31;
    step();
    check32("isr_wrap_pc", pc, 32'h0000_006C);
    check32("isr_wrap_savedpc", savedPc, 32'h0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/program_counter_unit.md
# program_counter_unit

Architectural program counter for the cpu32e2 core. Consumes the registered `programCounterGroup::controlBus` from the controller's program-counter output logic. Holds the current PC, computes the next PC per the control code, and captures the interrupted PC on ISR entry. It also detects misaligned branch targets and reports them through a sticky fault flag with an acknowledge handshake.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000; PC value after reset. Bits [1:0] must be 0.
- `clk`  input  1  core clock.
- `reset`  input  1  asynchronous, active-high.
- `enable`  input  1  stall control; 0 freezes PC and savedPc.
- `pcControl`  input  programCounterGroup::controlBus  NO_OP / LOAD_PLUS4 / LOAD_RFA / LOAD_CALC / LOAD_ISR.
- `rfaData`  input  32  register-file port A value (BR_R/BRL_R/IRET_R target).
- `calcData`  input  32  ALU-computed target (BR_PR/BR_RO/BRL_PR/BRL_RO).
- `vectorBase`  input  32  ISR table base; bits [1:0] ignored.
- `vectorIndex`  input  5  interrupt/exception cause index.
- `faultAck`  input  1  clears alignFault.
- `pc`  output  32  current PC.
- `pcPlus4`  output  32  pc + 4, combinational (link value for BRL).
- `savedPc`  output  32  PC captured on ISR entry.
- `alignFault`  output  1  sticky misaligned-target flag.
- `faultAddr`  output  32  offending target of the first unacknowledged fault.

## Operation
- Reset values:
  - `pc` = RESET_VECTOR.
  - `savedPc`, `faultAddr` = 0.
  - `alignFault` = 0.
  - `pcPlus4` = RESET_VECTOR + 4.
- Actions on a rising edge with enable=1, by control code:
  - NO_OP: hold.
  - LOAD_PLUS4: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - LOAD_RFA / LOAD_CALC: target = rfaData / calcData.
    - If target[1:0]==0: pc <= target.
    - Otherwise pc holds. If alignFault was 0, set alignFault and write faultAddr <= target.
  - LOAD_ISR: savedPc <= pc; pc <= {vectorBase[31:2],2'b00} + {vectorIndex,2'b00}, 32-bit wrap. No alignment check needed.
  - Undefined encodings behave as NO_OP.
- Fault rules:
  - First fault wins: while alignFault=1, later faults leave faultAddr unchanged. Legal loads still update pc.
  - faultAck is honoured regardless of enable and clears alignFault next edge.
  - faultAck coincident with a new fault in the same cycle (enable=1): the new fault wins. alignFault stays 1 and faultAddr takes the new target.
- enable=0: pc, savedPc, and new-fault capture are frozen; control code is ignored.
- Reset mid-operation forces reset values immediately (asynchronous), regardless of pcControl, enable, or faultAck.

## Timing
- One-cycle latency: a code applied at edge N is visible on `pc` after edge N.
- The controller registers pcControl, so a WRITEBACK-state LOAD_PLUS4 takes effect one edge after that state's decision edge.
- `pcPlus4` is purely combinational from `pc`, with zero latency and no register.
- alignFault asserts the cycle after the faulting edge and holds until the edge after faultAck=1 with no new fault.
- savedPc updates on the same edge as the ISR vector load.

## Structure
- Add to `programCounterGroup`: an `ALIGN_MASK` constant (2'b11) and a `vectorAddress` function (base + index*4). Keep the existing controlBus typedef.
- Sub-module `pc_target_select`: combinational next-PC mux plus alignment check. It outputs `nextPc`, `loadPc`, `faultDetect`, and `faultTarget`.
- The top level holds the pc, savedPc, alignFault, and faultAddr registers.

## Test plan
- Reset, then LOAD_PLUS4 ×3 -> pc = 0, 4, 8, 12. With pc=32'hFFFF_FFFC, LOAD_PLUS4 -> pc = 0.
- LOAD_CALC with calcData=32'h0000_1000 -> pc = 32'h1000. With enable=0 for 2 cycles and LOAD_PLUS4 driven, pc stays 32'h1000.
- LOAD_RFA with rfaData=32'h0000_2002 -> pc unchanged, alignFault=1, faultAddr=32'h2002. Then LOAD_CALC with 32'h3001 -> faultAddr still 32'h2002. Then faultAck -> alignFault=0.
- faultAck and LOAD_CALC with 32'h4003 in the same cycle -> alignFault stays 1, faultAddr = 32'h4003.
- With pc=32'h0000_0500, LOAD_ISR, vectorBase=32'h0000_8003, vectorIndex=5 -> savedPc=32'h500, pc=32'h8014.
- Reset asserted mid-stream (pc=32'h8014, alignFault=1) -> pc=RESET_VECTOR, alignFault=0, savedPc=0 immediately, before the next clk edge.
